dp_aux_req_arbiter: RTL and testbench

Shares the single AUX request/reply channel of the DP source between the Stream Policy Maker (SPM) and the Link Policy Maker (LPM).
- Accepts one request transaction at a time from either requester, using round-robin arbitration.
- Forwards the header and write bytes to the AUX transmitter.
- Routes the reply acknowledge and reply data back to the requester that owns the transaction.
- Generates a reply timeout.

It sits between the SPM/LPM request ports and the AUX TX/RX datapath.

---
 rtl/dp_aux_req_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_dp_aux_req_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_aux_req_arbiter.sv
// dp_aux_req_arbiter: shares the DP AUX request/reply channel between SPM and LPM.
// Round-robin grant, header/byte forwarding, reply routing and reply timeout.
module dp_aux_req_arbiter #(
    parameter int MAX_LEN     = 16,
    parameter int TIMEOUT_CYC = 400
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        spm_vld,
    input  logic [1:0]  spm_cmd,
    input  logic [19:0] spm_addr,
    input  logic [7:0]  spm_len,
    input  logic [7:0]  spm_data,
    output logic        spm_gnt,

    input  logic        lpm_vld,
    input  logic [1:0]  lpm_cmd,
    input  logic [19:0] lpm_addr,
    input  logic [7:0]  lpm_len,
    input  logic [7:0]  lpm_data,
    output logic        lpm_gnt,

    output logic        aux_tx_start,
    output logic [1:0]  aux_tx_cmd,
    output logic [19:0] aux_tx_addr,
    output logic [7:0]  aux_tx_len,
    output logic        aux_tx_data_vld,
    output logic [7:0]  aux_tx_data,

    input  logic        rx_ack_vld,
    input  logic [1:0]  rx_ack,
    input  logic        rx_data_vld,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,

    output logic        spm_reply_ack_vld,
    output logic [1:0]  spm_reply_ack,
    output logic        spm_reply_data_vld,
    output logic [7:0]  spm_reply_data,
    output logic        spm_native_i2c,

    output logic        lpm_reply_ack_vld,
    output logic [1:0]  lpm_reply_ack,
    output logic        lpm_reply_data_vld,
    output logic [7:0]  lpm_reply_data,
    output logic        lpm_native_i2c,

    output logic        arb_busy
);

    localparam logic [7:0] LEN_CAP = 8'(MAX_LEN - 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT_CYC);
    localparam logic [1:0] ACK_TMO = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_WAIT,
        S_REPLY
    } state_t;

    state_t        state_q;
    logic          owner_q;
    logic          last_lpm_q;
    logic [7:0]    cnt_q;
    logic [TW-1:0] tmo_q;

    logic          accept;
    logic [1:0]    req_cmd;
    logic [19:0]   req_addr;
    logic [7:0]    req_len;
    logic [7:0]    req_len_c;
    logic [7:0]    req_data;
    logic          own_vld;
    logic [7:0]    own_data;
    logic          tmo_hit;
    logic [1:0]    ack_val;

    // Grant only in IDLE; on a tie the requester not served last wins.
    always_comb begin
        spm_gnt = 1'b0;
        lpm_gnt = 1'b0;
        if (!reset && state_q == S_IDLE) begin
            if (spm_vld && lpm_vld) begin
                lpm_gnt = ~last_lpm_q;
                spm_gnt = last_lpm_q;
            end else begin
                spm_gnt = spm_vld;
                lpm_gnt = lpm_vld;
            end
        end
    end

    assign accept    = spm_gnt | lpm_gnt;
    assign req_cmd   = lpm_gnt ? lpm_cmd  : spm_cmd;
    assign req_addr  = lpm_gnt ? lpm_addr : spm_addr;
    assign req_len   = lpm_gnt ? lpm_len  : spm_len;
    assign req_data  = lpm_gnt ? lpm_data : spm_data;
    assign req_len_c = (req_len > LEN_CAP) ? LEN_CAP : req_len;

    assign own_vld   = owner_q ? lpm_vld  : spm_vld;
    assign own_data  = owner_q ? lpm_data : spm_data;

    assign tmo_hit   = (tmo_q == TMO_END);
    assign ack_val   = rx_ack_vld ? rx_ack : ACK_TMO;
    assign arb_busy  = (state_q != S_IDLE);

    // Transaction FSM with all forwarded and routed outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= S_IDLE;
            owner_q            <= 1'b0;
            last_lpm_q         <= 1'b0;
            cnt_q              <= '0;
            tmo_q              <= '0;
            aux_tx_start       <= 1'b0;
            aux_tx_cmd         <= '0;
            aux_tx_addr        <= '0;
            aux_tx_len         <= '0;
            aux_tx_data_vld    <= 1'b0;
            aux_tx_data        <= '0;
            spm_reply_ack_vld  <= 1'b0;
            spm_reply_ack      <= '0;
            spm_reply_data_vld <= 1'b0;
            spm_reply_data     <= '0;
            spm_native_i2c     <= 1'b0;
            lpm_reply_ack_vld  <= 1'b0;
            lpm_reply_ack      <= '0;
            lpm_reply_data_vld <= 1'b0;
            lpm_reply_data     <= '0;
            lpm_native_i2c     <= 1'b0;
        end else begin
            aux_tx_start       <= 1'b0;
            aux_tx_data_vld    <= 1'b0;
            aux_tx_data        <= '0;
            spm_reply_ack_vld  <= 1'b0;
            spm_reply_ack      <= '0;
            spm_reply_data_vld <= 1'b0;
            spm_reply_data     <= '0;
            spm_native_i2c     <= 1'b0;
            lpm_reply_ack_vld  <= 1'b0;
            lpm_reply_ack      <= '0;
            lpm_reply_data_vld <= 1'b0;
            lpm_reply_data     <= '0;
            lpm_native_i2c     <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        owner_q      <= lpm_gnt;
                        last_lpm_q   <= lpm_gnt;
                        aux_tx_start <= 1'b1;
                        aux_tx_cmd   <= req_cmd;
                        aux_tx_addr  <= req_addr;
                        aux_tx_len   <= req_len_c;
                        tmo_q        <= '0;
                        if (!req_cmd[0]) begin
                            aux_tx_data_vld <= 1'b1;
                            aux_tx_data     <= req_data;
                        end
                        if (!req_cmd[0] && req_len_c != 8'd0) begin
                            cnt_q   <= 8'd1;
                            state_q <= S_XFER;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_XFER: begin
                    if (own_vld) begin
                        aux_tx_data_vld <= 1'b1;
                        aux_tx_data     <= own_data;
                        if (cnt_q == aux_tx_len) begin
                            tmo_q   <= '0;
                            state_q <= S_WAIT;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                S_WAIT: begin
                    // Timeout ack lands TIMEOUT_CYC+1 cycles after entry.
                    if (rx_ack_vld || tmo_hit) begin
                        if (owner_q) begin
                            lpm_reply_ack_vld <= 1'b1;
                            lpm_reply_ack     <= ack_val;
                            lpm_native_i2c    <= aux_tx_cmd[1];
                        end else begin
                            spm_reply_ack_vld <= 1'b1;
                            spm_reply_ack     <= ack_val;
                            spm_native_i2c    <= aux_tx_cmd[1];
                        end
                        state_q <= rx_ack_vld ? S_REPLY : S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_REPLY: begin
                    if (owner_q) begin
                        lpm_reply_data_vld <= rx_data_vld;
                        lpm_reply_data     <= rx_data_vld ? rx_data : 8'd0;
                        lpm_native_i2c     <= aux_tx_cmd[1] &
                                              (rx_data_vld | ~rx_done);
                    end else begin
                        spm_reply_data_vld <= rx_data_vld;
                        spm_reply_data     <= rx_data_vld ? rx_data : 8'd0;
                        spm_native_i2c     <= aux_tx_cmd[1] &
                                              (rx_data_vld | ~rx_done);
                    end
                    if (rx_done) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_aux_req_arbiter.sv
// tb_dp_aux_req_arbiter: directed stimulus with queued expectations.
// A monitor pops and compares every TX and reply pulse the DUT emits.
module tb_dp_aux_req_arbiter;

    localparam int TMO = 8;

    typedef struct {
        logic [1:0]  cmd;
        logic [19:0] addr;
        logic [7:0]  len;
        int          cyc;
    } start_t;

    typedef struct {
        logic [1:0] ack;
        logic       nat;
        int         cyc;
    } ack_t;

    logic        clk;
    logic        reset;
    logic        spm_vld, lpm_vld;
    logic [1:0]  spm_cmd, lpm_cmd;
    logic [19:0] spm_addr, lpm_addr;
    logic [7:0]  spm_len, lpm_len;
    logic [7:0]  spm_data, lpm_data;
    logic        spm_gnt, lpm_gnt;
    logic        aux_tx_start;
    logic [1:0]  aux_tx_cmd;
    logic [19:0] aux_tx_addr;
    logic [7:0]  aux_tx_len;
    logic        aux_tx_data_vld;
    logic [7:0]  aux_tx_data;
    logic        rx_ack_vld;
    logic [1:0]  rx_ack;
    logic        rx_data_vld;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        spm_reply_ack_vld, lpm_reply_ack_vld;
    logic [1:0]  spm_reply_ack, lpm_reply_ack;
    logic        spm_reply_data_vld, lpm_reply_data_vld;
    logic [7:0]  spm_reply_data, lpm_reply_data;
    logic        spm_native_i2c, lpm_native_i2c;
    logic        arb_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    start_t     q_start[$];
    logic [7:0] q_tx[$];
    ack_t       q_spm_ack[$];
    ack_t       q_lpm_ack[$];
    logic [8:0] q_spm_dat[$];
    logic [8:0] q_lpm_dat[$];

    dp_aux_req_arbiter #(
        .MAX_LEN(16),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .spm_vld(spm_vld),
        .spm_cmd(spm_cmd),
        .spm_addr(spm_addr),
        .spm_len(spm_len),
        .spm_data(spm_data),
        .spm_gnt(spm_gnt),
        .lpm_vld(lpm_vld),
        .lpm_cmd(lpm_cmd),
        .lpm_addr(lpm_addr),
        .lpm_len(lpm_len),
        .lpm_data(lpm_data),
        .lpm_gnt(lpm_gnt),
        .aux_tx_start(aux_tx_start),
        .aux_tx_cmd(aux_tx_cmd),
        .aux_tx_addr(aux_tx_addr),
        .aux_tx_len(aux_tx_len),
        .aux_tx_data_vld(aux_tx_data_vld),
        .aux_tx_data(aux_tx_data),
        .rx_ack_vld(rx_ack_vld),
        .rx_ack(rx_ack),
        .rx_data_vld(rx_data_vld),
        .rx_data(rx_data),
        .rx_done(rx_done),
        .spm_reply_ack_vld(spm_reply_ack_vld),
        .spm_reply_ack(spm_reply_ack),
        .spm_reply_data_vld(spm_reply_data_vld),
        .spm_reply_data(spm_reply_data),
        .spm_native_i2c(spm_native_i2c),
        .lpm_reply_ack_vld(lpm_reply_ack_vld),
        .lpm_reply_ack(lpm_reply_ack),
        .lpm_reply_data_vld(lpm_reply_data_vld),
        .lpm_reply_data(lpm_reply_data),
        .lpm_native_i2c(lpm_native_i2c),
        .arb_busy(arb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected pulse %0h expected none", nm, act);
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always begin
        start_t     st;
        ack_t       ak;
        logic [8:0] dd;
        @(posedge clk);
        #1;
        if (aux_tx_start) begin
            if (q_start.size() == 0) bad("tx_start", {aux_tx_cmd, aux_tx_addr});
            else begin
                st = q_start.pop_front();
                chk("tx_hdr", {aux_tx_cmd, aux_tx_addr, aux_tx_len},
                    {st.cmd, st.addr, st.len});
                chk("tx_start_cyc", 64'(cyc), 64'(st.cyc));
            end
        end
        if (aux_tx_data_vld) begin
            if (q_tx.size() == 0) bad("tx_data", aux_tx_data);
            else chk("tx_data", aux_tx_data, q_tx.pop_front());
        end
        if (spm_reply_ack_vld) begin
            if (q_spm_ack.size() == 0) bad("spm_ack", spm_reply_ack);
            else begin
                ak = q_spm_ack.pop_front();
                chk("spm_ack", {spm_native_i2c, spm_reply_ack}, {ak.nat, ak.ack});
                if (ak.cyc >= 0) chk("spm_ack_cyc", 64'(cyc), 64'(ak.cyc));
            end
        end
        if (lpm_reply_ack_vld) begin
            if (q_lpm_ack.size() == 0) bad("lpm_ack", lpm_reply_ack);
            else begin
                ak = q_lpm_ack.pop_front();
                chk("lpm_ack", {lpm_native_i2c, lpm_reply_ack}, {ak.nat, ak.ack});
                if (ak.cyc >= 0) chk("lpm_ack_cyc", 64'(cyc), 64'(ak.cyc));
            end
        end
        if (spm_reply_data_vld) begin
            if (q_spm_dat.size() == 0) bad("spm_data", spm_reply_data);
            else begin
                dd = q_spm_dat.pop_front();
                chk("spm_data", {spm_native_i2c, spm_reply_data}, dd);
            end
        end
        if (lpm_reply_data_vld) begin
            if (q_lpm_dat.size() == 0) bad("lpm_data", lpm_reply_data);
            else begin
                dd = q_lpm_dat.pop_front();
                chk("lpm_data", {lpm_native_i2c, lpm_reply_data}, dd);
            end
        end
    end

    task automatic set_req(input bit lpm, input logic v, input logic [1:0] c,
                           input logic [19:0] a, input logic [7:0] l,
                           input logic [7:0] d);
        if (lpm) begin
            lpm_vld = v; lpm_cmd = c; lpm_addr = a; lpm_len = l; lpm_data = d;
        end else begin
            spm_vld = v; spm_cmd = c; spm_addr = a; spm_len = l; spm_data = d;
        end
    endtask

    task automatic req(input bit lpm, input logic [1:0] c, input logic [19:0] a,
                       input logic [7:0] l, input logic [7:0] d,
                       input logic [7:0] el);
        start_t s;
        set_req(lpm, 1'b1, c, a, l, d);
        #1;
        chk(lpm ? "lpm_gnt" : "spm_gnt", lpm ? lpm_gnt : spm_gnt, 1);
        chk(lpm ? "spm_gnt_lose" : "lpm_gnt_lose", lpm ? spm_gnt : lpm_gnt, 0);
        s.cmd = c; s.addr = a; s.len = el; s.cyc = cyc + 1;
        q_start.push_back(s);
        if (!c[0]) q_tx.push_back(d);
        @(negedge clk);
    endtask

    task automatic wbyte(input bit lpm, input logic v, input logic [7:0] d);
        if (lpm) begin lpm_vld = v; lpm_data = d; end
        else begin spm_vld = v; spm_data = d; end
        if (v) q_tx.push_back(d);
        @(negedge clk);
    endtask

    task automatic rx(input logic av, input logic [1:0] a, input logic dv,
                      input logic [7:0] d, input logic dn);
        rx_ack_vld = av; rx_ack = a; rx_data_vld = dv; rx_data = d; rx_done = dn;
        @(negedge clk);
        rx_ack_vld = 0; rx_ack = 0; rx_data_vld = 0; rx_data = 0; rx_done = 0;
    endtask

    task automatic push_ack(input bit lpm, input logic [1:0] a, input logic n,
                            input int c);
        ack_t k;
        k.ack = a; k.nat = n; k.cyc = c;
        if (lpm) q_lpm_ack.push_back(k);
        else q_spm_ack.push_back(k);
    endtask

    task automatic push_dat(input bit lpm, input logic n, input logic [7:0] d);
        if (lpm) q_lpm_dat.push_back({n, d});
        else q_spm_dat.push_back({n, d});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        reset = 1'b1;
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        rx_ack_vld = 0; rx_ack = 0; rx_data_vld = 0; rx_data = 0; rx_done = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", arb_busy, 0);
        chk("rst_tx_start", aux_tx_start, 0);
        chk("rst_tx_dvld", aux_tx_data_vld, 0);
        chk("rst_tx_addr", aux_tx_addr, 0);
        chk("rst_spm_ack_vld", spm_reply_ack_vld, 0);
        chk("rst_lpm_ack_vld", lpm_reply_ack_vld, 0);
        reset = 1'b0;
        @(negedge clk);

        // tie from reset: LPM wins, 4-byte write A1..A4
        set_req(0, 1, 2'b01, 20'h00200, 8'd0, 8'h00);
        req(1, 2'b00, 20'h00102, 8'd3, 8'hA1, 8'd3);
        wbyte(1, 1, 8'hA2);
        wbyte(1, 1, 8'hA3);
        wbyte(1, 1, 8'hA4);
        lpm_vld = 0;
        push_ack(1, 2'b00, 1'b0, -1);
        rx(1, 2'b00, 0, 8'h00, 0);
        #1 chk("busy_reply", arb_busy, 1);
        rx(0, 2'b00, 0, 8'h00, 1);

        // SPM held its request; it is granted next
        #1 chk("busy_idle", arb_busy, 0);
        req(0, 2'b01, 20'h00200, 8'd0, 8'h00, 8'd0);
        spm_vld = 0;
        rx(0, 2'b00, 1, 8'h33, 0);
        push_ack(0, 2'b00, 1'b0, -1);
        rx(1, 2'b00, 0, 8'h00, 0);
        push_dat(0, 1'b0, 8'h5A);
        rx(0, 2'b00, 1, 8'h5A, 0);
        rx(0, 2'b00, 0, 8'h00, 1);
        rx(0, 2'b00, 1, 8'h44, 0);

        // native write with owner stall and non-owner noise
        req(1, 2'b10, 20'h00300, 8'd2, 8'hB1, 8'd2);
        spm_vld = 1; spm_data = 8'hCC;
        wbyte(1, 0, 8'h00);
        spm_vld = 0;
        wbyte(1, 0, 8'h00);
        wbyte(1, 1, 8'hB2);
        wbyte(1, 1, 8'hB3);
        lpm_vld = 0;
        push_ack(1, 2'b01, 1'b1, -1);
        rx(1, 2'b01, 0, 8'h00, 0);
        push_dat(1, 1'b1, 8'h77);
        rx(0, 2'b00, 1, 8'h77, 1);

        // tie after LPM: SPM wins; len 0x20 clamps to 15
        set_req(1, 1, 2'b01, 20'h00999, 8'd0, 8'h00);
        req(0, 2'b00, 20'h00500, 8'h20, 8'h00, 8'h0F);
        lpm_vld = 0;
        for (int i = 1; i < 16; i++) wbyte(0, 1, 8'(i));
        spm_data = 8'hFF;
        @(negedge clk);
        spm_vld = 0;
        push_ack(0, 2'b10, 1'b0, -1);
        rx(1, 2'b10, 0, 8'h00, 0);
        rx(0, 2'b00, 0, 8'h00, 1);

        // reply timeout on an SPM read
        c0 = cyc;
        req(0, 2'b01, 20'h00600, 8'd0, 8'h00, 8'd0);
        spm_vld = 0;
        push_ack(0, 2'b11, 1'b0, c0 + 1 + TMO + 1);
        rx(0, 2'b00, 1, 8'h12, 0);
        repeat (10) @(negedge clk);
        chk("busy_after_tmo", arb_busy, 0);

        // reset during REPLY drops the transaction
        req(1, 2'b11, 20'h00400, 8'd0, 8'h00, 8'd0);
        lpm_vld = 0;
        push_ack(1, 2'b00, 1'b1, -1);
        rx(1, 2'b00, 0, 8'h00, 0);
        #1 chk("lpm_native_hold", lpm_native_i2c, 1);
        push_dat(1, 1'b1, 8'h99);
        rx(0, 2'b00, 1, 8'h99, 0);
        reset = 1'b1;
        rx_data_vld = 1; rx_data = 8'hEE;
        @(posedge clk);
        #1;
        chk("mid_rst_busy", arb_busy, 0);
        chk("mid_rst_native", lpm_native_i2c, 0);
        chk("mid_rst_dvld", lpm_reply_data_vld, 0);
        chk("mid_rst_hdr", {aux_tx_cmd, aux_tx_addr, aux_tx_len}, 0);
        @(negedge clk);
        reset = 1'b0;
        rx_data_vld = 0; rx_data = 0;
        rx(0, 2'b00, 0, 8'h00, 1);
        rx(1, 2'b00, 1, 8'h55, 0);
        repeat (3) @(negedge clk);

        chk("q_start_empty", q_start.size(), 0);
        chk("q_tx_empty", q_tx.size(), 0);
        chk("q_spm_ack_empty", q_spm_ack.size(), 0);
        chk("q_lpm_ack_empty", q_lpm_ack.size(), 0);
        chk("q_spm_dat_empty", q_spm_dat.size(), 0);
        chk("q_lpm_dat_empty", q_lpm_dat.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
